// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - parametrised valid/ready pipeline stage register with optional skid entry
module pipe_stage_skid_reg #(
    parameter int                 DATA_W   = 32,
    parameter int                 CTRL_W   = 16,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
    parameter bit                 SKID     = 1'b1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [1:0]        o_occupancy
);

    logic              m_valid, m_valid_n;
    logic [DATA_W-1:0] m_data, m_data_n;
    logic [CTRL_W-1:0] m_ctrl, m_ctrl_n;
    logic              s_valid, s_valid_n;
    logic [DATA_W-1:0] s_data, s_data_n;
    logic [CTRL_W-1:0] s_ctrl, s_ctrl_n;
    logic              ready_q, ready_n;
    logic [1:0]        occ_q, occ_n;
    logic              up_xfer;

    assign o_ready     = SKID ? ready_q : (~m_valid | i_ready);
    assign o_valid     = m_valid;
    assign o_data      = m_data;
    assign o_ctrl      = m_ctrl;
    assign o_occupancy = occ_q;
    assign up_xfer     = i_valid & o_ready;

    always_comb begin
        m_valid_n = m_valid;
        m_data_n  = m_data;
        m_ctrl_n  = m_ctrl;
        s_valid_n = s_valid;
        s_data_n  = s_data;
        s_ctrl_n  = s_ctrl;
        if (!SKID) begin
            if (up_xfer) begin
                m_valid_n = 1'b1;
                m_data_n  = i_data;
                m_ctrl_n  = i_ctrl;
            end else if (m_valid && i_ready) begin
                m_valid_n = 1'b0;
                m_ctrl_n  = CTRL_NOP;
            end
        end else begin
            if (s_valid && i_ready) begin
                m_valid_n = 1'b1;
                m_data_n  = s_data;
                m_ctrl_n  = s_ctrl;
                s_valid_n = 1'b0;
            end else if (!s_valid && up_xfer && (!m_valid || i_ready)) begin
                m_valid_n = 1'b1;
                m_data_n  = i_data;
                m_ctrl_n  = i_ctrl;
            end else if (!s_valid && up_xfer) begin
                s_valid_n = 1'b1;
                s_data_n  = i_data;
                s_ctrl_n  = i_ctrl;
            end else if (!up_xfer && i_ready) begin
                m_valid_n = 1'b0;
                m_ctrl_n  = CTRL_NOP;
            end
        end
        // Flush discards any accepted beat; the payload register keeps its last value.
        if (flush) begin
            m_valid_n = 1'b0;
            m_data_n  = m_data;
            m_ctrl_n  = CTRL_NOP;
            s_valid_n = 1'b0;
        end
        ready_n = ~s_valid_n;
        occ_n   = {1'b0, m_valid_n} + {1'b0, s_valid_n};
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= CTRL_NOP;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_ctrl  <= CTRL_NOP;
            ready_q <= 1'b1;
            occ_q   <= 2'd0;
        end else begin
            m_valid <= m_valid_n;
            m_data  <= m_data_n;
            m_ctrl  <= m_ctrl_n;
            s_valid <= s_valid_n;
            s_data  <= s_data_n;
            s_ctrl  <= s_ctrl_n;
            ready_q <= ready_n;
            occ_q   <= occ_n;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - scoreboard bench for skid and non-skid stage instances
module tb_pipe_stage_skid_reg;

    typedef struct {
        logic [31:0] d;
        logic [15:0] c;
    } beat_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic [31:0] i_data = '0;
    logic [15:0] i_ctrl = '0;

    logic        o_ready_a [2];
    logic        o_valid_a [2];
    logic [31:0] o_data_a  [2];
    logic [15:0] o_ctrl_a  [2];
    logic [1:0]  o_occ_a   [2];

    localparam logic [15:0] NOP0 = 16'h0000;
    localparam logic [15:0] NOP1 = 16'h00A5;

    beat_t       q [2][$];
    logic [31:0] exp_data [2];
    logic [15:0] nop_a [2];
    bit          skid_a [2];
    bit          started = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(16), .CTRL_NOP(NOP0), .SKID(1'b1)) dut_skid (
        .clk(clk), .nrst(nrst), .flush(flush), .i_valid(i_valid), .o_ready(o_ready_a[0]),
        .i_data(i_data), .i_ctrl(i_ctrl), .o_valid(o_valid_a[0]), .i_ready(i_ready),
        .o_data(o_data_a[0]), .o_ctrl(o_ctrl_a[0]), .o_occupancy(o_occ_a[0])
    );

    pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(16), .CTRL_NOP(NOP1), .SKID(1'b0)) dut_flat (
        .clk(clk), .nrst(nrst), .flush(flush), .i_valid(i_valid), .o_ready(o_ready_a[1]),
        .i_data(i_data), .i_ctrl(i_ctrl), .o_valid(o_valid_a[1]), .i_ready(i_ready),
        .o_data(o_data_a[1]), .o_ctrl(o_ctrl_a[1]), .o_occupancy(o_occ_a[1])
    );

    task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL inst%0d %s actual=%h required=%h at %0t", k, nm, act, req, $time);
        end
    endtask

    // Monitor + reference model: the stage is a FIFO of at most 2 (skid) or 1 (flat) beats.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int    n;
            bit    rdy, up, dn;
            n = q[k].size();
            rdy = skid_a[k] ? (n < 2) : (n == 0 || i_ready);
            if (started) begin
                chk(k, "o_valid", {31'd0, o_valid_a[k]}, {31'd0, n != 0});
                chk(k, "o_occupancy", {30'd0, o_occ_a[k]}, n);
                chk(k, "o_ready", {31'd0, o_ready_a[k]}, {31'd0, rdy});
                chk(k, "o_data", o_data_a[k], exp_data[k]);
                chk(k, "o_ctrl", {16'd0, o_ctrl_a[k]}, {16'd0, (n != 0) ? q[k][0].c : nop_a[k]});
            end
            if (!nrst) begin
                q[k].delete();
                exp_data[k] = '0;
            end else if (started) begin
                dn = (n != 0) && i_ready;
                up = i_valid && rdy;
                if (dn) void'(q[k].pop_front());
                if (flush) q[k].delete();
                else if (up) q[k].push_back('{d: i_data, c: i_ctrl});
                if (q[k].size() != 0) exp_data[k] = q[k][0].d;
            end
        end
        if (!nrst) started = 1'b1;
    end

    task automatic cyc(input bit v, input logic [31:0] d, input logic [15:0] c,
                       input bit r, input bit f, input bit rn);
        i_valid = v;
        i_data  = d;
        i_ctrl  = c;
        i_ready = r;
        flush   = f;
        nrst    = rn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nop_a[0] = NOP0;
        nop_a[1] = NOP1;
        skid_a[0] = 1'b1;
        skid_a[1] = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // Streaming
        for (int i = 0; i < 16; i++) cyc(1, 32'h10 + i, 16'(i + 1), 1, 0, 1);
        // Bubble after a beat with ctrl 0x00FF
        cyc(1, 32'h5A5A, 16'h00FF, 1, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 32'hDEAD, 16'h1234, 1, 0, 1);
        // Backpressure into the skid entry, then drain
        cyc(1, 32'hA0, 16'h0A0, 0, 0, 1);
        cyc(1, 32'hA1, 16'h0A1, 0, 0, 1);
        cyc(1, 32'hA2, 16'h0A2, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 1);
        // Flush with full stage and an upstream beat
        cyc(1, 32'hB0, 16'h0B0, 0, 0, 1);
        cyc(1, 32'hB1, 16'h0B1, 0, 0, 1);
        cyc(1, 32'hCC, 16'h0CC, 0, 1, 1);
        cyc(0, 0, 0, 1, 0, 1);
        // Flush with one beat held and an accepted upstream beat
        cyc(1, 32'hB2, 16'h0B2, 0, 0, 1);
        cyc(1, 32'hCC, 16'h0CC, 1, 1, 1);
        cyc(0, 0, 0, 1, 0, 1);
        // Reset mid-stream with two beats held
        cyc(1, 32'hE0, 16'h0E0, 0, 0, 1);
        cyc(1, 32'hE1, 16'h0E1, 0, 0, 1);
        cyc(1, 32'hE2, 16'h0E2, 1, 1, 0);
        cyc(0, 0, 0, 1, 0, 1);
        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(99) < 70, $urandom, 16'($urandom),
                $urandom_range(99) < 60, $urandom_range(99) < 3, $urandom_range(199) != 0);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
